// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch stage: owns the PC, keeps a DEPTH-entry {instr, pc} FIFO for decode.
// Optional feature macro: FETCH_HALT_ON_ZERO_EN (a fetched zero word halts fetching).
module fetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         flush_en,
    input  logic [ADDR_W-1:0]            flush_pc,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_ack,
    input  logic [INSTR_W-1:0]           mem_data,
    output logic                         out_valid,
    output logic [INSTR_W-1:0]           out_instr,
    output logic [ADDR_W-1:0]            out_pc,
    input  logic                         out_ready,
    output logic                         halted,
    output logic [1:0]                   dbg_state_o,
    output logic [$clog2(DEPTH+1)-1:0]   dbg_count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                outstanding_q, outstanding_d;
    logic                discard_q, discard_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [INSTR_W-1:0]  fifo_instr_q [DEPTH];
    logic [ADDR_W-1:0]   fifo_pc_q    [DEPTH];

    logic                flush_act, ack_hit, ack_use, zero_hit, push, pop;
    logic                busy_after, issue;
    logic [ADDR_W-1:0]   pc_base;

    // Decode handshake: the head transfers on a rising edge where out_valid && out_ready;
    // out_valid never drops and out_instr/out_pc never change while waiting on out_ready,
    // except that a flush empties the queue. mem_ack answers the single outstanding request.
    always_comb begin
        flush_act = flush_en && (state_q != S_HALT);
        ack_hit   = mem_ack && outstanding_q;
        ack_use   = ack_hit && !discard_q && !flush_act;
`ifdef FETCH_HALT_ON_ZERO_EN
        zero_hit  = ack_use && (mem_data == '0);
`else
        zero_hit  = 1'b0;
`endif
        push      = ack_use && !zero_hit;
        pop       = out_valid && out_ready && !flush_act;

        state_d = state_q;
        if (flush_act) begin
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_IDLE:  if (en) state_d = S_RUN;
                S_RUN:   if (zero_hit) state_d = S_HALT;
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end

        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush_act) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end

        // An ack in the flush cycle retires the in-flight request, so nothing is left to discard.
        busy_after = outstanding_q && !mem_ack;
        discard_d  = flush_act ? busy_after : (discard_q && !ack_hit);

        pc_base = flush_act ? flush_pc : fetch_pc_q;
        issue   = (state_d == S_RUN) && !busy_after && (count_d < CNT_W'(DEPTH));

        outstanding_d = busy_after || issue;
        mem_req_d     = issue;
        mem_addr_d    = issue ? pc_base : mem_addr_q;
        fetch_pc_d    = issue ? (pc_base + ADDR_W'(4)) : pc_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // mem_addr_q still holds the outstanding request's address when its ack arrives.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= mem_data;
            fifo_pc_q[wr_ptr_q]    <= mem_addr_q;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign out_valid   = (count_q != '0);
    assign out_instr   = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign out_pc      = out_valid ? fifo_pc_q[rd_ptr_q] : '0;
`ifdef FETCH_HALT_ON_ZERO_EN
    assign halted      = (state_q == S_HALT);
`else
    assign halted      = 1'b0;
`endif
    assign dbg_state_o = state_q;
    assign dbg_count_o = count_q;

endmodule
